// File: rtl/gauss_pkg.sv
// Shared types and width helpers for the Gaussian convolution sequencer.
package gauss_pkg;

    // Sequencer FSM states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        TAP   = 3'd1,
        FLUSH = 3'd2,
        EMIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int DEF_KSIZE = 5;

    // $clog2 that never returns 0, so degenerate sizes still get a 1-bit bus
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int row_w(input int rows);
        return clog2_min1(rows);
    endfunction

    function automatic int col_w(input int cols);
        return clog2_min1(cols);
    endfunction

    function automatic int addr_w(input int rows, input int cols);
        return clog2_min1(rows * cols);
    endfunction

    function automatic int coef_w(input int ksize);
        return clog2_min1(ksize * ksize);
    endfunction

    // Width of an unsigned kernel index 0..KSIZE-1
    function automatic int kidx_w(input int ksize);
        return clog2_min1(ksize);
    endfunction

endpackage

// File: rtl/gauss_tap_walker.sv
// Walks the KSIZE x KSIZE kernel taps (offsets +C down to -C, rows outer),
// bounds-checks each tap against the image and forms pixel address and
// coefficient index for it.
module gauss_tap_walker
    import gauss_pkg::*;
#(
    parameter int ROWS  = 192,
    parameter int COLS  = 192,
    parameter int KSIZE = DEF_KSIZE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          step,
    input  logic [row_w(ROWS)-1:0]        row,
    input  logic [col_w(COLS)-1:0]        col,
    output logic                          first,
    output logic                          last,
    output logic                          in_bounds,
    output logic [addr_w(ROWS, COLS)-1:0] addr,
    output logic [coef_w(KSIZE)-1:0]      coef
);

    localparam int IW = kidx_w(KSIZE);
    localparam int OW = IW + 1;
    localparam int RW = row_w(ROWS);
    localparam int CW = col_w(COLS);
    localparam int AW = addr_w(ROWS, COLS);
    localparam int KW = coef_w(KSIZE);
    localparam int MW = (RW > CW) ? RW : CW;
    localparam int YW = ((MW > OW) ? MW : OW) + 2;
    localparam int C  = KSIZE / 2;

    localparam logic [IW-1:0]        KMAX   = IW'(KSIZE - 1);
    localparam logic signed [YW-1:0] ROWS_S = YW'(ROWS);
    localparam logic signed [YW-1:0] COLS_S = YW'(COLS);

    // ki/li hold C+k and C+l, so they count KSIZE-1 down to 0
    logic [IW-1:0]        ki;
    logic [IW-1:0]        li;
    logic signed [OW-1:0] k_ofs;
    logic signed [OW-1:0] l_ofs;
    logic signed [YW-1:0] y;
    logic signed [YW-1:0] z;

    // Kernel down-counters: inner l, outer k; wrap back to the first tap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ki <= KMAX;
            li <= KMAX;
        end else if (clr) begin
            ki <= KMAX;
            li <= KMAX;
        end else if (step) begin
            if (li == '0) begin
                li <= KMAX;
                ki <= (ki == '0) ? KMAX : ki - IW'(1);
            end else begin
                li <= li - IW'(1);
            end
        end
    end

    // Signed tap coordinates, bounds test and address / coefficient formation
    always_comb begin
        first     = (ki == KMAX) && (li == KMAX);
        last      = (ki == '0) && (li == '0);
        k_ofs     = $signed({1'b0, ki}) - $signed(OW'(C));
        l_ofs     = $signed({1'b0, li}) - $signed(OW'(C));
        y         = $signed({{(YW - RW){1'b0}}, row}) + $signed({{(YW - OW){k_ofs[OW-1]}}, k_ofs});
        z         = $signed({{(YW - CW){1'b0}}, col}) + $signed({{(YW - OW){l_ofs[OW-1]}}, l_ofs});
        in_bounds = !y[YW-1] && (y < ROWS_S) && !z[YW-1] && (z < COLS_S);
        addr      = '0;
        if (in_bounds) begin
            addr = AW'(y[RW-1:0]) * AW'(COLS) + AW'(z[CW-1:0]);
        end
        coef      = KW'(ki) * KW'(KSIZE) + KW'(li);
    end

endmodule

// File: rtl/gauss_conv_sequencer.sv
// Raster-order pixel sequencer for the 2-D Gaussian convolution datapath.
// Handshake: the presented pixel (out_row/out_col) is accepted on a cycle
// where out_valid and out_ready are both high; out_valid, out_row and out_col
// hold steady until then, and out_valid never drops without acceptance
// except on abort or reset.
module gauss_conv_sequencer
    import gauss_pkg::*;
#(
    parameter int ROWS   = 192,
    parameter int COLS   = 192,
    parameter int KSIZE  = DEF_KSIZE,
    parameter int RD_LAT = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    output logic                          busy,
    output logic                          done,
    output logic                          rd_en,
    output logic [addr_w(ROWS, COLS)-1:0] rd_addr,
    output logic [coef_w(KSIZE)-1:0]      coef_idx,
    output logic                          mac_en,
    output logic                          mac_clr,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [row_w(ROWS)-1:0]        out_row,
    output logic [col_w(COLS)-1:0]        out_col,
    output state_t                        dbg_state
);

    localparam int RW = row_w(ROWS);
    localparam int CW = col_w(COLS);
    localparam int AW = addr_w(ROWS, COLS);
    localparam int KW = coef_w(KSIZE);
    localparam int FW = clog2_min1(RD_LAT);

    state_t              state;
    state_t              nxt;
    logic [RW-1:0]       row;
    logic [CW-1:0]       col;
    logic [FW-1:0]       fl_cnt;
    logic [RD_LAT-1:0]   rd_pipe;
    logic [RD_LAT-1:0]   clr_pipe;

    logic                tap_first;
    logic                tap_last;
    logic                tap_inb;
    logic [AW-1:0]       tap_addr;
    logic [KW-1:0]       tap_coef;

    logic                kill;
    logic                hs;
    logic                last_pix;

    assign kill     = abort && (state != IDLE);
    assign hs       = (state == EMIT) && out_ready && !abort;
    assign last_pix = (row == RW'(ROWS - 1)) && (col == CW'(COLS - 1));

    gauss_tap_walker #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .KSIZE (KSIZE)
    ) u_walker (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (kill || (state != TAP)),
        .step      (state == TAP),
        .row       (row),
        .col       (col),
        .first     (tap_first),
        .last      (tap_last),
        .in_bounds (tap_inb),
        .addr      (tap_addr),
        .coef      (tap_coef)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Next-state and output decode; abort overrides every transition
    always_comb begin
        nxt       = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        coef_idx  = '0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) nxt = TAP;
            end
            TAP: begin
                busy     = 1'b1;
                rd_en    = tap_inb;
                rd_addr  = tap_inb ? tap_addr : '0;
                coef_idx = tap_coef;
                if (tap_last) nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (fl_cnt == FW'(RD_LAT - 1)) nxt = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (hs) nxt = last_pix ? DONE : TAP;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (kill) nxt = IDLE;
    end

    assign mac_en    = rd_pipe[RD_LAT-1];
    assign mac_clr   = clr_pipe[RD_LAT-1];
    assign out_row   = row;
    assign out_col   = col;
    assign dbg_state = state;

    // Raster position: restart at (0,0) on start/abort, advance on each handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (kill || ((state == IDLE) && start)) begin
            row <= '0;
            col <= '0;
        end else if (hs) begin
            if (col == CW'(COLS - 1)) begin
                col <= '0;
                row <= last_pix ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // FLUSH length counter, idle at zero outside FLUSH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fl_cnt <= '0;
        end else if ((state == FLUSH) && !kill) begin
            fl_cnt <= fl_cnt + FW'(1);
        end else begin
            fl_cnt <= '0;
        end
    end

    // Read-latency delay line that lines rd_en/first-tap up with returned data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pipe  <= '0;
            clr_pipe <= '0;
        end else if (kill) begin
            rd_pipe  <= '0;
            clr_pipe <= '0;
        end else begin
            rd_pipe[0]  <= rd_en;
            clr_pipe[0] <= (state == TAP) && tap_first;
            for (int i = 1; i < RD_LAT; i++) begin
                rd_pipe[i]  <= rd_pipe[i-1];
                clr_pipe[i] <= clr_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_gauss_conv_sequencer.sv
// Directed bench for gauss_conv_sequencer on a 4x4 image with a 3x3 kernel.
module tb_gauss_conv_sequencer;
    import gauss_pkg::*;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int NK = 3;
    localparam int KC = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // DUT with RD_LAT=1
    logic         start, abort, out_ready;
    logic         busy, done, rd_en, mac_en, mac_clr, out_valid;
    logic [3:0]   rd_addr;
    logic [3:0]   coef_idx;
    logic [1:0]   out_row, out_col;
    state_t       dbg_state;

    // DUT with RD_LAT=3
    logic         start3, abort3, out_ready3;
    logic         busy3, done3, rd_en3, mac_en3, mac_clr3, out_valid3;
    logic [3:0]   rd_addr3;
    logic [3:0]   coef_idx3;
    logic [1:0]   out_row3, out_col3;
    state_t       dbg_state3;

    gauss_conv_sequencer #(.ROWS(NR), .COLS(NC), .KSIZE(NK), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .busy(busy), .done(done),
        .rd_en(rd_en), .rd_addr(rd_addr), .coef_idx(coef_idx), .mac_en(mac_en), .mac_clr(mac_clr),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_col(out_col),
        .dbg_state(dbg_state)
    );

    gauss_conv_sequencer #(.ROWS(NR), .COLS(NC), .KSIZE(NK), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .busy(busy3), .done(done3),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .coef_idx(coef_idx3), .mac_en(mac_en3), .mac_clr(mac_clr3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_row(out_row3), .out_col(out_col3),
        .dbg_state(dbg_state3)
    );

    // ---------------- scoreboard ----------------
    int compared   = 0;
    int mismatched = 0;
    int tot_rd     = 0;
    logic [15:0] exp_q[$];   // {addr[7:0], coef[7:0]} of each in-bounds tap, in issue order

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected in-bounds taps of pixel (r,c), k and l from +KC down to -KC
    task automatic push_pixel(input int r, input int c);
        for (int k = KC; k >= -KC; k--) begin
            for (int l = KC; l >= -KC; l--) begin
                if ((r + k) >= 0 && (r + k) < NR && (c + l) >= 0 && (c + l) < NC) begin
                    exp_q.push_back({8'((r + k) * NC + (c + l)), 8'((KC + k) * NK + (KC + l))});
                end
            end
        end
    endtask

    function automatic int exp_cnt(input int r, input int c);
        int nr = 0;
        int nc = 0;
        for (int k = -KC; k <= KC; k++) begin
            if ((r + k) >= 0 && (r + k) < NR) nr++;
            if ((c + k) >= 0 && (c + k) < NC) nc++;
        end
        return nr * nc;
    endfunction

    // Run a frame on the RD_LAT=1 DUT with optional backpressure, stray start and abort
    task automatic run_frame(input int bp_p, input int bp_n, input int stray_p, input int abort_p);
        int          p;
        int          cnt;
        int          pix_cycles;
        int          ev;
        logic        prev_rd;
        logic [15:0] e;
        p = 0; cnt = 0; pix_cycles = 0; ev = 0; prev_rd = 1'b0; tot_rd = 0;
        exp_q.delete();
        push_pixel(0, 0);
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            pix_cycles++;
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("mac_en_delay", mac_en, prev_rd);
            chk("mac_clr", mac_clr, (pix_cycles == 2));
            if (rd_en) begin
                cnt++;
                tot_rd++;
                if (exp_q.size() == 0) begin
                    chk("tap_extra", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_addr", rd_addr, e[15:8]);
                    chk("coef_idx", coef_idx, e[7:0]);
                end
            end
            prev_rd = rd_en;
            if (p == abort_p && pix_cycles == 5) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk("abort_busy", busy, 0);
                chk("abort_rd_en", rd_en, 0);
                chk("abort_mac_en", mac_en, 0);
                chk("abort_valid", out_valid, 0);
                chk("abort_state", dbg_state, IDLE);
                for (int i = 0; i < 15; i++) begin
                    tick();
                    chk("post_abort_mac_en", mac_en, 0);
                    chk("post_abort_done", done, 0);
                    chk("post_abort_busy", busy, 0);
                end
                return;
            end
            start = (p == stray_p && pix_cycles == 3);
            if (out_valid) begin
                ev++;
                chk("out_row", out_row, p / NC);
                chk("out_col", out_col, p % NC);
                chk("emit_rd_en", rd_en, 0);
                out_ready = !(p == bp_p && ev <= bp_n);
                if (out_ready) begin
                    chk("rd_count", cnt, exp_cnt(p / NC, p % NC));
                    chk("emit_cycles", ev, (p == bp_p) ? bp_n + 1 : 1);
                    chk("pixel_cycles", pix_cycles, 11 + ((p == bp_p) ? bp_n : 0));
                    p++;
                    cnt = 0; pix_cycles = 0; ev = 0;
                    if (p == NR * NC) begin
                        tick();
                        chk("done_pulse", done, 1);
                        chk("done_busy", busy, 0);
                        tick();
                        chk("done_once", done, 0);
                        chk("end_state", dbg_state, IDLE);
                        return;
                    end
                    push_pixel(p / NC, p % NC);
                end
            end
            tick();
        end
        chk("frame_timeout", p, NR * NC);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    int   hist[0:63];
    logic seen;

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start3 = 1'b0; abort3 = 1'b0; out_ready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_coef", coef_idx, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clr", mac_clr, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst_state", dbg_state, IDLE);
        rst_n = 1'b1;
        tick();

        // Pixel (0,0) in detail, held in EMIT, then abort together with out_ready
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_state", dbg_state, TAP);
        chk("t1_rd_en", rd_en, 1);
        chk("t1_addr", rd_addr, 5);
        chk("t1_coef", coef_idx, 8);
        chk("t1_clr", mac_clr, 0);
        tick();
        chk("t2_addr", rd_addr, 4);
        chk("t2_coef", coef_idx, 7);
        chk("t2_clr", mac_clr, 1);
        chk("t2_mac_en", mac_en, 1);
        tick();
        chk("t3_rd_en", rd_en, 0);
        chk("t3_addr", rd_addr, 0);
        chk("t3_coef", coef_idx, 6);
        chk("t3_clr", mac_clr, 0);
        repeat (7) tick();
        chk("c10_state", dbg_state, FLUSH);
        chk("c10_valid", out_valid, 0);
        chk("c10_mac_en", mac_en, 0);
        tick();
        chk("c11_valid", out_valid, 1);
        chk("c11_row", out_row, 0);
        chk("c11_col", out_col, 0);
        tick();
        chk("c12_valid_hold", out_valid, 1);
        abort = 1'b1;
        out_ready = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab1_valid", out_valid, 0);
        chk("ab1_busy", busy, 0);
        chk("ab1_done", done, 0);
        chk("ab1_state", dbg_state, IDLE);
        tick();
        chk("ab1_done_late", done, 0);

        // Abort at tap 5 of pixel (2,1)
        run_frame(-1, 0, -1, 2 * NC + 1);

        // Full frame from (0,0) with backpressure at (1,2) and a stray start at (1,1)
        run_frame(1 * NC + 2, 7, 1 * NC + 1, -1);
        chk("frame_rd_total", tot_rd, 100);

        // Reset while presenting pixel (0,1)
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (out_valid && out_col == 2'd1) seen = 1'b1;
            else tick();
        end
        chk("rst_mid_reached", seen, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_col", out_col, 0);
        chk("rst_mid_state", dbg_state, IDLE);
        #1;
        rst_n = 1'b1;
        tick();
        chk("rst_mid_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("rst_restart_addr", rd_addr, 5);
        chk("rst_restart_col", out_col, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // RD_LAT=3 DUT: two pixels
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int n = 1; n <= 26; n++) begin
            hist[n] = int'(rd_en3);
            if (n == 1) begin
                chk("l3_addr", rd_addr3, 5);
                chk("l3_coef", coef_idx3, 8);
            end
            if (n > 3) chk("l3_mac_en", mac_en3, hist[n-3]);
            else       chk("l3_mac_en_early", mac_en3, 0);
            chk("l3_mac_clr", mac_clr3, (n == 4 || n == 17));
            chk("l3_valid", out_valid3, (n == 13 || n == 26));
            if (n >= 10 && n <= 12) chk("l3_flush", dbg_state3, FLUSH);
            if (n == 26) begin
                chk("l3_row", out_row3, 0);
                chk("l3_col", out_col3, 1);
            end
            tick();
        end
        abort3 = 1'b1;
        tick();
        abort3 = 1'b0;
        chk("l3_abort_busy", busy3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
